// File: rtl/colour_pwm_driver.sv
// Colour-selector sink: maps a 3-bit colour code and a global brightness onto
// three PWM LED pins, with a linear crossfade whenever the target duties change.
module colour_pwm_driver #(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned FADE_DIV = 4,
  parameter int unsigned STEP     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       colour,
  input  logic [PWM_W-1:0] brightness,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             busy
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CALC_W = PWM_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t state, state_d;

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_r, duty_g, duty_b;
  logic [PWM_W-1:0] duty_r_d, duty_g_d, duty_b_d;
  logic [PWM_W-1:0] tgt_r, tgt_g, tgt_b;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_d;
  logic             at_target;

  // One fade step toward the target, saturating at it; one spare bit so d+STEP cannot wrap.
  function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] duty,
                                                   input logic [PWM_W-1:0] tgt);
    logic [CALC_W-1:0] d, t, s, r;
    d = CALC_W'(duty);
    t = CALC_W'(tgt);
    s = CALC_W'(STEP);
    r = d;
    if (d < t) begin
      r = ((d + s) > t) ? t : (d + s);
    end else if (d > t) begin
      r = (d < (t + s)) ? t : (d - s);
    end
    return r[PWM_W-1:0];
  endfunction

  assign at_target = (duty_r == tgt_r) && (duty_g == tgt_g) && (duty_b == tgt_b);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, divider and duty updates for the crossfade.
  always_comb begin
    state_d  = state;
    div_d    = div_q;
    duty_r_d = duty_r;
    duty_g_d = duty_g;
    duty_b_d = duty_b;
    busy_d   = 1'b0;
    case (state)
      IDLE: begin
        div_d = '0;
        if (!at_target) begin
          state_d = FADE;
        end
      end
      FADE: begin
        if (at_target) begin
          state_d = IDLE;
        end else if (div_q == DIV_W'(FADE_DIV - 1)) begin
          div_d    = '0;
          duty_r_d = step_toward(duty_r, tgt_r);
          duty_g_d = step_toward(duty_g, tgt_g);
          duty_b_d = step_toward(duty_b, tgt_b);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FADE);
  end

  // Datapath registers: targets, duties, PWM counter and registered pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
      duty_g  <= '0;
      duty_b  <= '0;
      tgt_r   <= '0;
      tgt_g   <= '0;
      tgt_b   <= '0;
      div_q   <= '0;
      busy    <= 1'b0;
      led_r   <= 1'b0;
      led_g   <= 1'b0;
      led_b   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      tgt_r   <= colour[0] ? brightness : '0;
      tgt_g   <= colour[1] ? brightness : '0;
      tgt_b   <= colour[2] ? brightness : '0;
      duty_r  <= duty_r_d;
      duty_g  <= duty_g_d;
      duty_b  <= duty_b_d;
      div_q   <= div_d;
      busy    <= busy_d;
      led_r   <= (duty_r > pwm_cnt);
      led_g   <= (duty_g > pwm_cnt);
      led_b   <= (duty_b > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_colour_pwm_driver.sv
// Self-checking bench for colour_pwm_driver: directed scenarios plus random
// colour/brightness traffic against an integer model of the fade rules.
module tb_colour_pwm_driver;

  localparam int unsigned PWM_W    = 8;
  localparam int unsigned FADE_DIV = 4;
  localparam int unsigned STEP     = 16;
  localparam int          PERIOD   = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       colour = 3'd0;
  logic [PWM_W-1:0] brightness = '0;
  logic             led_r, led_g, led_b, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: duties/targets as plain integers, fade phase as edges since last step.
  int   m_duty[3];
  int   m_tgt[3];
  int   m_cnt;
  int   m_phase;
  logic m_busy;
  logic m_led[3];

  colour_pwm_driver #(.PWM_W(PWM_W), .FADE_DIV(FADE_DIV), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .colour(colour), .brightness(brightness),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic diff;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_duty[i] = 0; m_tgt[i] = 0; m_led[i] = 1'b0;
      end
      m_cnt = 0; m_phase = 0; m_busy = 1'b0;
    end else begin
      diff = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_led[i] = (m_duty[i] > m_cnt);
        if (m_duty[i] != m_tgt[i]) diff = 1'b1;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
      if (!m_busy) begin
        if (diff) begin m_busy = 1'b1; m_phase = 0; end
      end else if (!diff) begin
        m_busy = 1'b0;
      end else begin
        m_phase++;
        if (m_phase == int'(FADE_DIV)) begin
          m_phase = 0;
          for (int i = 0; i < 3; i++) begin
            if (m_tgt[i] > m_duty[i])
              m_duty[i] = (m_tgt[i] - m_duty[i] <= int'(STEP)) ? m_tgt[i] : m_duty[i] + int'(STEP);
            else if (m_tgt[i] < m_duty[i])
              m_duty[i] = (m_duty[i] - m_tgt[i] <= int'(STEP)) ? m_tgt[i] : m_duty[i] - int'(STEP);
          end
        end
      end
      for (int i = 0; i < 3; i++) m_tgt[i] = colour[i] ? int'(brightness) : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [27:0] obs();
    return {led_r, led_g, led_b, busy, dut.duty_r, dut.duty_g, dut.duty_b};
  endfunction

  function automatic logic [27:0] exp_vec();
    return {m_led[0], m_led[1], m_led[2], m_busy, 8'(m_duty[0]), 8'(m_duty[1]), 8'(m_duty[2])};
  endfunction

  task automatic test_reset();
    rst = 1'b0; colour = 3'b111; brightness = 8'd255;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({led_r, led_g, led_b, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: leds/busy=%b want 0000", c, {led_r, led_g, led_b, busy});
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
    end
    colour = 3'b000; rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_fade_up();
    int   rise = -1, len = -1, first_step = -1, gb_high = 0;
    logic prev_busy = 1'b0;
    logic [7:0] prev_duty = 8'd0;
    int   seq[$];
    int   want[$];
    for (int v = 16; v <= 240; v += 16) want.push_back(v);
    want.push_back(255);
    brightness = 8'd255; colour = 3'b001;
    for (int c = 1; c <= 100; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL fade_up cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (busy && !prev_busy) rise = c;
      if (!busy && prev_busy && len < 0) len = c - rise;
      if (dut.duty_r != prev_duty) begin
        seq.push_back(int'(dut.duty_r));
        if (first_step < 0) first_step = c;
      end
      if (led_g || led_b) gb_high++;
      prev_busy = busy; prev_duty = dut.duty_r;
    end
    checks++;
    if (rise != 2) begin errors++; $display("FAIL fade_up_busy_rise: cycle %0d want 2", rise); end
    checks++;
    if (first_step - rise != int'(FADE_DIV)) begin
      errors++; $display("FAIL fade_up_first_step: offset %0d want %0d", first_step - rise, FADE_DIV);
    end
    checks++;
    if (len != 65) begin errors++; $display("FAIL fade_up_busy_len: %0d want 65", len); end
    checks++;
    if (seq != want) begin errors++; $display("FAIL fade_up_seq: %0d steps want %0d", seq.size(), want.size()); end
    checks++;
    if (gb_high != 0) begin errors++; $display("FAIL fade_up_gb: %0d high cycles want 0", gb_high); end
  endtask

  task automatic test_steady();
    int g_cnt = 0, rb_cnt = 0;
    colour = 3'b010; brightness = 8'd128;
    for (int c = 0; c < 150; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL steady_settle cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
    end
    for (int c = 0; c < PERIOD; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL steady cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (led_g) g_cnt++;
      if (led_r || led_b) rb_cnt++;
    end
    checks++;
    if (g_cnt != 128) begin errors++; $display("FAIL steady_g_count: %0d want 128", g_cnt); end
    checks++;
    if (rb_cnt != 0) begin errors++; $display("FAIL steady_rb_count: %0d want 0", rb_cnt); end
  endtask

  task automatic test_crossfade();
    int   rise = -1, len = -1;
    logic prev_busy = 1'b0;
    logic [7:0] prev_r;
    int   pr[$];
    int   pb[$];
    colour = 3'b001; brightness = 8'd64;
    for (int c = 0; c < 150; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL xfade_settle cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
    end
    prev_r = dut.duty_r;
    colour = 3'b100;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL xfade cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (busy && !prev_busy) rise = c;
      if (!busy && prev_busy && len < 0) len = c - rise;
      if (dut.duty_r != prev_r) begin pr.push_back(int'(dut.duty_r)); pb.push_back(int'(dut.duty_b)); end
      prev_busy = busy; prev_r = dut.duty_r;
    end
    checks++;
    if (len != 17) begin errors++; $display("FAIL xfade_busy_len: %0d want 17", len); end
    checks++;
    if (pr.size() != 4) begin
      errors++; $display("FAIL xfade_steps: %0d want 4", pr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pr[i] != 48 - 16 * i || pb[i] != 16 + 16 * i) begin
          errors++;
          $display("FAIL xfade_step%0d: r=%0d b=%0d want r=%0d b=%0d", i, pr[i], pb[i], 48 - 16 * i, 16 + 16 * i);
        end
      end
    end
  endtask

  task automatic test_retarget();
    int   seq[$];
    int   zero_c = -1, idle_c = -1, early_drop = 0;
    logic [7:0] prev_r;
    logic found = 1'b0;
    colour = 3'b000;
    for (int c = 0; c < 100; c++) tick();
    brightness = 8'd255; colour = 3'b001;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL retarget_up cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (dut.duty_r == 8'd80) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL retarget_reach80: duty_r=%0d want 80", dut.duty_r); end
    prev_r = dut.duty_r;
    colour = 3'b000;
    for (int c = 1; c <= 60; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL retarget_down cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (dut.duty_r != prev_r) seq.push_back(int'(dut.duty_r));
      if (!busy && dut.duty_r != 8'd0) early_drop++;
      if (dut.duty_r == 8'd0 && zero_c < 0) zero_c = c;
      if (!busy && idle_c < 0) idle_c = c;
      prev_r = dut.duty_r;
    end
    checks++;
    if (seq.size() != 5 || seq[0] != 64 || seq[4] != 0) begin
      errors++; $display("FAIL retarget_seq: %0d steps want 5 (64..0)", seq.size());
    end
    checks++;
    if (early_drop != 0) begin errors++; $display("FAIL retarget_busy_gap: %0d cycles want 0", early_drop); end
    checks++;
    if (idle_c != zero_c + 1) begin
      errors++; $display("FAIL retarget_busy_fall: cycle %0d want %0d", idle_c, zero_c + 1);
    end
  endtask

  task automatic test_noop();
    int active = 0;
    colour = 3'b111; brightness = 8'd0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL noop cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
      if (busy || led_r || led_g || led_b) active++;
    end
    checks++;
    if (active != 0) begin errors++; $display("FAIL noop_active: %0d cycles want 0", active); end
  endtask

  task automatic test_reset_mid_fade();
    colour = 3'b111; brightness = 8'd200;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midfade_busy: %b want 1", busy); end
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== 28'd0) begin errors++; $display("FAIL midfade_reset: got %h want 0", obs()); end
    colour = 3'b000; rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL midfade_after cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        colour = 3'($urandom_range(0, 7));
        brightness = 8'($urandom);
      end
      rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h want %h", c, obs(), exp_vec());
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_steady();
    test_crossfade();
    test_retarget();
    test_noop();
    test_reset_mid_fade();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/colour_pwm_driver.md
Name: colour_pwm_driver

Overview:
- Sink end of the colour-selector interface: consumes the 3-bit `colour` code produced by the button-driven lights cycler and drives three physical LED pins (R, G, B).
- Each colour bit is a channel on/off request, scaled by a global `brightness`.
- Each channel is rendered as PWM, and colour changes are smoothed by a linear crossfade state machine.
- Sits between the lights cycler and the board LED pins.

Parameters:
- PWM_W, 8: width of PWM counter, duty registers and `brightness`.
- FADE_DIV, 4: clock cycles per fade step, valid range 1 to 255.
- STEP, 16: duty increment/decrement per fade step, valid range 1 to 2^PWM_W-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- colour  input  3  colour code; bit0=red, bit1=green, bit2=blue; all 8 codes legal (000 all off, 111 white).
- brightness  input  PWM_W  target duty for any enabled channel.
- led_r  output  1  red PWM output, registered.
- led_g  output  1  green PWM output, registered.
- led_b  output  1  blue PWM output, registered.
- busy  output  1  high while a fade is in progress, registered.

Behaviour:
- Reset (rst==0 at a clock edge):
  - pwm_cnt, duty_r/g/b, tgt_r/g/b and the divider all clear to 0.
  - State goes to IDLE.
  - led_r, led_g, led_b and busy all go to 0.
- Target registers:
  - Every edge out of reset, tgt_x <= colour[i] ? brightness : 0.
  - Inputs are therefore sampled once per cycle, and targets lag the inputs by 1 cycle.
- PWM counter:
  - pwm_cnt increments every cycle, wrapping from 2^PWM_W-1 to 0 (period 2^PWM_W cycles).
- PWM outputs:
  - led_x <= (duty_x > pwm_cnt).
  - duty 0 gives a constant 0.
  - duty D gives exactly D high cycles per period.
  - Maximum duty is (2^PWM_W-1)/2^PWM_W; full-on is unreachable by design.
- FSM, 2 states:
  - IDLE: busy=0, divider held at 0. If any duty_x != tgt_x, go to FADE at the next edge.
  - FADE: busy=1.
    - The divider counts 0..FADE_DIV-1.
    - On the edge where divider==FADE_DIV-1, each channel steps: duty_x moves toward tgt_x by STEP, saturating at tgt_x (no overshoot), and the divider returns to 0.
    - On any edge in FADE with all duty_x == tgt_x, go to IDLE; duties and divider are unchanged on that edge.
- Channel independence:
  - Channels step in parallel and may rise and fall simultaneously.
  - Channels already at target hold.
- Arithmetic:
  - Step computed at PWM_W+1 bits to avoid wrap.
  - Rising: duty = min(duty+STEP, tgt).
  - Falling: duty = max(duty-STEP, tgt).
- Latency:
  - Input change captured at edge k (targets update).
  - busy=1 from edge k+1.
  - First duty step at edge k+1+FADE_DIV.
  - Subsequent steps every FADE_DIV cycles.
  - Total steps = max over channels of ceil(|tgt-duty|/STEP).
  - busy falls one edge after the final step.
- Retarget mid-fade:
  - Targets update continuously.
  - FADE continues toward the new targets without restarting the divider.
  - If the new targets equal the current duties, return to IDLE on the next edge.
- brightness change with an unchanged colour is treated as a retarget and fades.
- Reset mid-fade: all of the above clear immediately on that edge; no residual steps.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with colour=111, brightness=255 -> led_r/g/b=0 and busy=0 throughout; then release.
2. Fade up (colour 000->001, brightness=255, defaults):
   - busy high 1 cycle after target update.
   - duty_r steps 16,32,…,240,255: 16 steps, 64 cycles.
   - busy low 65 cycles after going high.
   - led_g=led_b=0 throughout.
3. Steady PWM: after a fade to colour=010, brightness=128 -> over any 256 consecutive cycles led_g high exactly 128 cycles; led_r=led_b=0.
4. Crossfade 001->100 at brightness=64: red falls 64→48→32→16→0 while blue rises 0→16→…→64 on the same step edges; 4 steps; busy 16+1 cycles.
5. Retarget mid-fade: fade 000->001 (255); after 5 steps (duty 80) apply colour=000 -> duty falls 64,48,…,0 with no overshoot; busy stays high continuously until duty 0, then falls.
6. No-op/reset cases:
   - colour=111 with brightness=0 -> busy never asserts, outputs 0.
   - Assert rst=0 during an active fade -> next edge duty=0, busy=0, all LEDs 0.
